// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM burst test client: FSM encoding,
// data-pattern seed and error codes reported on err_code.
`timescale 1ns/1ps
package sdram_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_REQ   = 3'd1,
        S_WR_BURST = 3'd2,
        S_RD_REQ   = 3'd3,
        S_RD_BURST = 3'd4,
        S_NEXT     = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam logic [15:0] PATTERN_SEED = 16'hA55A;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_DATA = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

endpackage

// File: rtl/sdram_pattern_gen.sv
// Combinational test pattern: word i of burst b is the low 16 bits of the
// linear word address XOR the pattern seed.
`timescale 1ns/1ps
module sdram_pattern_gen
    import sdram_pkg::*;
#(
    parameter int BURST_LEN = 256
) (
    input  logic [15:0] burst_idx,
    input  logic [15:0] word_idx,
    output logic [15:0] word
);

    logic [31:0] lin_addr;

    always_comb begin
        lin_addr = 32'(burst_idx) * 32'(BURST_LEN) + 32'(word_idx);
        word     = lin_addr[15:0] ^ PATTERN_SEED;
    end

endmodule

// File: rtl/sdram_burst_client.sv
// Self-test client for an SDRAM controller: writes NUM_BURSTS bursts of a
// known pattern, reads each back, checks it and counts error-free passes.
`timescale 1ns/1ps
module sdram_burst_client
    import sdram_pkg::*;
#(
    parameter int BURST_LEN  = 256,
    parameter int NUM_BURSTS = 4,
    parameter int LOOP       = 1,
    parameter int TMO_CLK    = 4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_init_done,
    output logic        sdram_wr_req,
    output logic        sdram_rd_req,
    input  logic        sdram_wr_ack,
    input  logic        sdram_rd_ack,
    output logic [8:0]  sdwr_byte,
    output logic [8:0]  sdrd_byte,
    output logic [21:0] sys_addr,
    output logic [15:0] sys_data_in,
    input  logic [15:0] sys_data_out,
    output logic [15:0] pass_cnt,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        busy,
    output state_t      dbg_state
);

    // Handshake: a request is held high until the controller's first ack;
    // every ack-high clock then transfers exactly one word, and the first
    // ack-low clock after that marks the end of the burst.

    localparam int TW = (TMO_CLK > 1) ? $clog2(TMO_CLK + 1) : 1;

    state_t        state, state_n;
    logic [15:0]   b_idx, b_n;
    logic [15:0]   w_idx, w_n;
    logic [TW-1:0] tmo_cnt, tmo_n;
    logic [15:0]   pass_n;
    logic          err_hit;
    logic [1:0]    err_hit_code;

    logic [15:0]   pat_word;
    logic [15:0]   w_inc;
    logic          len_bad;
    logic          tmo_last;
    logic          b_last;
    logic          rd_mismatch;

    sdram_pattern_gen #(
        .BURST_LEN (BURST_LEN)
    ) u_pattern (
        .burst_idx (b_idx),
        .word_idx  (w_idx),
        .word      (pat_word)
    );

    always_comb begin
        w_inc       = (w_idx == 16'hFFFF) ? w_idx : w_idx + 16'd1;
        len_bad     = (w_idx != 16'(BURST_LEN));
        tmo_last    = (tmo_cnt == TW'(TMO_CLK - 1));
        b_last      = ((32'(b_idx) + 32'd1) >= 32'(NUM_BURSTS));
        rd_mismatch = (sys_data_out != pat_word);
    end

    always_comb begin
        state_n      = state;
        b_n          = b_idx;
        w_n          = w_idx;
        tmo_n        = tmo_cnt;
        pass_n       = pass_cnt;
        err_hit      = 1'b0;
        err_hit_code = ERR_NONE;

        case (state)
            S_IDLE: begin
                b_n   = '0;
                w_n   = '0;
                tmo_n = '0;
                if (sdram_init_done) state_n = S_WR_REQ;
            end
            S_WR_REQ: begin
                if (sdram_wr_ack) begin
                    w_n     = w_inc;
                    tmo_n   = '0;
                    state_n = S_WR_BURST;
                end else if (tmo_last) begin
                    err_hit      = 1'b1;
                    err_hit_code = ERR_TMO;
                    state_n      = S_DONE;
                end else begin
                    tmo_n = tmo_cnt + 1'b1;
                end
            end
            S_WR_BURST: begin
                if (sdram_wr_ack) begin
                    w_n = w_inc;
                end else begin
                    if (len_bad) begin
                        err_hit      = 1'b1;
                        err_hit_code = ERR_LEN;
                    end
                    w_n     = '0;
                    tmo_n   = '0;
                    state_n = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (sdram_rd_ack) begin
                    if (rd_mismatch) begin
                        err_hit      = 1'b1;
                        err_hit_code = ERR_DATA;
                    end
                    w_n     = w_inc;
                    tmo_n   = '0;
                    state_n = S_RD_BURST;
                end else if (tmo_last) begin
                    err_hit      = 1'b1;
                    err_hit_code = ERR_TMO;
                    state_n      = S_DONE;
                end else begin
                    tmo_n = tmo_cnt + 1'b1;
                end
            end
            S_RD_BURST: begin
                if (sdram_rd_ack) begin
                    if (rd_mismatch) begin
                        err_hit      = 1'b1;
                        err_hit_code = ERR_DATA;
                    end
                    w_n = w_inc;
                end else begin
                    if (len_bad) begin
                        err_hit      = 1'b1;
                        err_hit_code = ERR_LEN;
                    end
                    state_n = S_NEXT;
                end
            end
            S_NEXT: begin
                w_n   = '0;
                tmo_n = '0;
                if (b_last) begin
                    state_n = S_DONE;
                    if (!err) pass_n = pass_cnt + 16'd1;
                end else begin
                    b_n     = b_idx + 16'd1;
                    state_n = S_WR_REQ;
                end
            end
            S_DONE: begin
                if (LOOP != 0) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // Losing the controller aborts the pass; the pass is not counted.
        if (state != S_IDLE && !sdram_init_done) begin
            state_n = S_IDLE;
            b_n     = '0;
            w_n     = '0;
            tmo_n   = '0;
            pass_n  = pass_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            b_idx    <= '0;
            w_idx    <= '0;
            tmo_cnt  <= '0;
            pass_cnt <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_n;
            b_idx    <= b_n;
            w_idx    <= w_n;
            tmo_cnt  <= tmo_n;
            pass_cnt <= pass_n;
            if (err_hit && !err) begin
                err      <= 1'b1;
                err_code <= err_hit_code;
            end
        end
    end

    always_comb begin
        sdram_wr_req = (state == S_WR_REQ);
        sdram_rd_req = (state == S_RD_REQ);
        sdwr_byte    = 9'(BURST_LEN);
        sdrd_byte    = 9'(BURST_LEN);
        sys_addr     = 22'(32'(b_idx) * 32'(BURST_LEN));
        sys_data_in  = (state == S_WR_REQ || state == S_WR_BURST) ? pat_word : 16'h0000;
        busy         = (state != S_IDLE) && (state != S_DONE);
        dbg_state    = state;
    end

endmodule

// File: tb/tb_sdram_burst_client.sv
// Directed bench: a behavioural SDRAM controller model drives acks and read
// data; each task checks one behaviour of the burst client.
`timescale 1ns/1ps
module tb_sdram_burst_client;
    import sdram_pkg::*;

    localparam int BL  = 256;
    localparam int NB  = 4;
    localparam int TMO = 4095;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sdram_init_done = 1'b0;
    logic        sdram_wr_ack = 1'b0;
    logic        sdram_rd_ack = 1'b0;
    logic [15:0] sys_data_out = 16'h0000;
    logic        sdram_wr_req, sdram_rd_req;
    logic [8:0]  sdwr_byte, sdrd_byte;
    logic [21:0] sys_addr;
    logic [15:0] sys_data_in;
    logic [15:0] pass_cnt;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;
    state_t      dbg_state;

    int errors = 0;
    int checks = 0;
    int both_cnt = 0;
    logic [15:0] exp_q[$];

    // clock / reset
    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) if (sdram_wr_req && sdram_rd_req) both_cnt++;

    sdram_burst_client #(
        .BURST_LEN  (BL),
        .NUM_BURSTS (NB),
        .LOOP       (1),
        .TMO_CLK    (TMO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sdram_init_done (sdram_init_done),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_rd_req    (sdram_rd_req),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_rd_ack    (sdram_rd_ack),
        .sdwr_byte       (sdwr_byte),
        .sdrd_byte       (sdrd_byte),
        .sys_addr        (sys_addr),
        .sys_data_in     (sys_data_in),
        .sys_data_out    (sys_data_out),
        .pass_cnt        (pass_cnt),
        .err             (err),
        .err_code        (err_code),
        .busy            (busy),
        .dbg_state       (dbg_state)
    );

    function automatic logic [15:0] exp_word(input int b, input int k);
        logic [31:0] t;
        t = b * BL + k;
        return t[15:0] ^ 16'hA55A;
    endfunction

    // driver tasks
    task automatic apply_reset();
        rst_n = 1'b0;
        sdram_init_done = 1'b0;
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        sys_data_out = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_req(input bit rd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if ((rd ? sdram_rd_req : sdram_wr_req) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL req_seen rd=%0d: got none, expected request within 6000 clocks", rd);
        end
    endtask

    task automatic wait_state(input state_t s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if (dbg_state === s) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL state_seen: got %0d, expected %0d within 6000 clocks", dbg_state, s);
        end
    endtask

    task automatic write_burst(input int b, input int n);
        bit ok;
        int bad;
        logic req_after;
        logic [15:0] e;
        wait_req(1'b0, ok);
        if (!ok) return;
        checks++;
        if (sys_addr !== 22'(b * BL)) begin
            errors++;
            $display("FAIL wr_addr b%0d: got %0d expected %0d", b, sys_addr, b * BL);
        end
        for (int k = 0; k < n; k++) exp_q.push_back(exp_word(b, k));
        bad = 0;
        req_after = 1'b0;
        for (int k = 0; k < n; k++) begin
            sdram_wr_ack = 1'b1;
            #1;
            e = exp_q.pop_front();
            if (sys_data_in !== e) bad++;
            if (k == 1) req_after = sdram_wr_req;
            @(negedge clk);
        end
        sdram_wr_ack = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wr_data b%0d: got %0d wrong words, expected 0", b, bad);
        end
        if (n > 1) begin
            checks++;
            if (req_after !== 1'b0) begin
                errors++;
                $display("FAIL wr_req_drop b%0d: got %b expected 0", b, req_after);
            end
        end
    endtask

    task automatic read_burst(input int b, input int n, input int bad_k);
        bit ok;
        logic req_after;
        wait_req(1'b1, ok);
        if (!ok) return;
        checks++;
        if (sys_addr !== 22'(b * BL)) begin
            errors++;
            $display("FAIL rd_addr b%0d: got %0d expected %0d", b, sys_addr, b * BL);
        end
        req_after = 1'b0;
        for (int k = 0; k < n; k++) begin
            sdram_rd_ack = 1'b1;
            sys_data_out = (k == bad_k) ? 16'h0000 : exp_word(b, k);
            #1;
            if (k == 1) req_after = sdram_rd_req;
            @(negedge clk);
        end
        sdram_rd_ack = 1'b0;
        sys_data_out = 16'h0000;
        if (n > 1) begin
            checks++;
            if (req_after !== 1'b0) begin
                errors++;
                $display("FAIL rd_req_drop b%0d: got %b expected 0", b, req_after);
            end
        end
    endtask

    task automatic halt_after_done();
        sdram_init_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // scenarios
    task automatic test_reset();
        apply_reset();
        checks++;
        if (dbg_state !== S_IDLE || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got state=%0d busy=%b expected 0/0", dbg_state, busy);
        end
        checks++;
        if (sdram_wr_req !== 1'b0 || sdram_rd_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: got wr=%b rd=%b expected 0/0", sdram_wr_req, sdram_rd_req);
        end
        checks++;
        if (sys_addr !== 22'd0 || sys_data_in !== 16'h0000) begin
            errors++;
            $display("FAIL reset_bus: got addr=%h data=%h expected 0/0", sys_addr, sys_data_in);
        end
        checks++;
        if (pass_cnt !== 16'd0 || err !== 1'b0 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL reset_status: got pass=%0d err=%b code=%0d expected 0/0/0", pass_cnt, err, err_code);
        end
        checks++;
        if (sdwr_byte !== 9'd256 || sdrd_byte !== 9'd256) begin
            errors++;
            $display("FAIL burst_len: got wr=%0d rd=%0d expected 256", sdwr_byte, sdrd_byte);
        end
    endtask

    task automatic test_full_pass();
        bit ok;
        sdram_init_done = 1'b1;
        for (int b = 0; b < NB; b++) begin
            write_burst(b, BL);
            read_burst(b, BL, -1);
        end
        wait_state(S_DONE, ok);
        checks++;
        if (pass_cnt !== 16'd1 || err !== 1'b0 || err_code !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_pass: got pass=%0d err=%b code=%0d busy=%b expected 1/0/0/0",
                     pass_cnt, err, err_code, busy);
        end
        halt_after_done();
        checks++;
        if (dbg_state !== S_IDLE || pass_cnt !== 16'd1) begin
            errors++;
            $display("FAIL full_pass_halt: got state=%0d pass=%0d expected 0/1", dbg_state, pass_cnt);
        end
    endtask

    task automatic test_init_drop();
        bit ok;
        sdram_init_done = 1'b1;
        write_burst(0, BL);
        read_burst(0, BL, -1);
        wait_req(1'b0, ok);
        checks++;
        if (sys_addr !== 22'd256) begin
            errors++;
            $display("FAIL drop_addr: got %0d expected 256", sys_addr);
        end
        for (int k = 0; k < 10; k++) begin
            sdram_wr_ack = 1'b1;
            @(negedge clk);
        end
        sdram_wr_ack = 1'b0;
        sdram_init_done = 1'b0;
        @(negedge clk);
        checks++;
        if (dbg_state !== S_IDLE || sdram_wr_req !== 1'b0 || sdram_rd_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle: got state=%0d wr=%b rd=%b busy=%b expected 0/0/0/0",
                     dbg_state, sdram_wr_req, sdram_rd_req, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (dbg_state !== S_IDLE || pass_cnt !== 16'd1) begin
            errors++;
            $display("FAIL drop_hold: got state=%0d pass=%0d expected 0/1", dbg_state, pass_cnt);
        end
        sdram_init_done = 1'b1;
        write_burst(0, BL);
        halt_after_done();
    endtask

    task automatic test_data_mismatch();
        bit ok;
        apply_reset();
        sdram_init_done = 1'b1;
        for (int b = 0; b < NB; b++) begin
            write_burst(b, BL);
            read_burst(b, BL, (b == 2) ? 5 : -1);
        end
        wait_state(S_DONE, ok);
        checks++;
        if (err !== 1'b1 || err_code !== 2'd1 || pass_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mismatch: got err=%b code=%0d pass=%0d expected 1/1/0", err, err_code, pass_cnt);
        end
        halt_after_done();
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        sdram_init_done = 1'b1;
        write_burst(0, BL);
        wait_req(1'b1, ok);
        for (int k = 0; k < 10; k++) begin
            sdram_rd_ack = 1'b1;
            sys_data_out = exp_word(0, k);
            @(negedge clk);
        end
        rst_n = 1'b0;
        sdram_wr_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (dbg_state !== S_IDLE || sdram_wr_req !== 1'b0 || sdram_rd_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_state: got state=%0d wr=%b rd=%b busy=%b expected 0/0/0/0",
                     dbg_state, sdram_wr_req, sdram_rd_req, busy);
        end
        checks++;
        if (sys_addr !== 22'd0 || sys_data_in !== 16'h0000 || pass_cnt !== 16'd0
            || err !== 1'b0 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_status: got addr=%0d data=%h pass=%0d err=%b code=%0d expected all 0",
                     sys_addr, sys_data_in, pass_cnt, err, err_code);
        end
        @(negedge clk);
        checks++;
        if (sdram_wr_req !== 1'b0 || sdram_rd_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ack: got wr=%b rd=%b expected 0/0 while acks high", sdram_wr_req, sdram_rd_req);
        end
        apply_reset();
    endtask

    task automatic test_short_write();
        bit ok;
        apply_reset();
        sdram_init_done = 1'b1;
        write_burst(0, BL - 1);
        wait_req(1'b1, ok);
        checks++;
        if (err !== 1'b1 || err_code !== 2'd2 || sys_addr !== 22'd0) begin
            errors++;
            $display("FAIL short_write: got err=%b code=%0d addr=%0d expected 1/2/0", err, err_code, sys_addr);
        end
        apply_reset();
    endtask

    task automatic test_timeout();
        bit ok;
        int cnt;
        sdram_init_done = 1'b1;
        write_burst(0, BL);
        wait_req(1'b1, ok);
        cnt = 0;
        for (int i = 0; i < 6000; i++) begin
            if (sdram_rd_req !== 1'b1) break;
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== TMO) begin
            errors++;
            $display("FAIL tmo_len: got %0d request clocks expected %0d", cnt, TMO);
        end
        checks++;
        if (dbg_state !== S_DONE || sdram_rd_req !== 1'b0 || err !== 1'b1 || err_code !== 2'd3
            || pass_cnt !== 16'd0) begin
            errors++;
            $display("FAIL tmo_status: got state=%0d rd=%b err=%b code=%0d pass=%0d expected 6/0/1/3/0",
                     dbg_state, sdram_rd_req, err, err_code, pass_cnt);
        end
        halt_after_done();
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_init_drop();
        test_data_mismatch();
        test_reset_mid_read();
        test_short_write();
        test_timeout();
        checks++;
        if (both_cnt !== 0) begin
            errors++;
            $display("FAIL req_exclusive: got %0d clocks with both requests, expected 0", both_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
